// File: rtl/decoder_pkg.sv
//------------------------------------------------------------------------------
// decoder_pkg : shared widths, FSM encoding and one-hot helper for decoder_pulse
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package decoder_pkg;

  localparam int c_code_w  = 3;
  localparam int c_out_w   = 8;
  localparam int c_timer_w = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [c_out_w-1:0] onehot_of(input logic [c_code_w-1:0] code);
    return c_out_w'(1) << code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_hold_timer.sv
//------------------------------------------------------------------------------
// decoder_hold_timer : loadable down-counter with zero flag, async reset
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decoder_hold_timer
  import decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [c_timer_w-1:0] load_val_i,
  input  logic                 dec_i,
  input  logic                 clr_i,
  output logic                 zero_o
);

  logic [c_timer_w-1:0] count_q;
  logic [c_timer_w-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/decoder_pulse.sv
//------------------------------------------------------------------------------
// decoder_pulse : 3-to-8 decoder whose one-hot output is held for HOLD_CYCLES
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decoder_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [c_code_w-1:0]  in_code,
  output logic                 in_ready,
  output logic [c_out_w-1:0]   Y,
  output logic                 out_valid,
  output logic [c_timer_w-1:0] accept_cnt
);

  state_e               state_q, state_d;
  logic [c_out_w-1:0]   y_q, y_d;
  logic                 ov_q, ov_d;
  logic [c_timer_w-1:0] cnt_q;

  logic w_transfer;
  logic w_tmr_load;
  logic w_tmr_dec;
  logic w_tmr_clr;
  logic w_tmr_zero;

  // Gated by rst so nothing looks acceptable while reset is being applied.
  assign in_ready   = (state_q == ST_IDLE) && en && !rst;
  assign w_transfer = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    ov_d       = ov_q;
    w_tmr_load = 1'b0;
    w_tmr_dec  = 1'b0;
    w_tmr_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_transfer) begin
          state_d    = ST_HOLD;
          y_d        = onehot_of(in_code);
          ov_d       = 1'b1;
          w_tmr_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!en) begin
          state_d   = ST_IDLE;
          y_d       = '0;
          ov_d      = 1'b0;
          w_tmr_clr = 1'b1;
        end else if (w_tmr_zero) begin
          state_d = ST_GAP;
          y_d     = '0;
          ov_d    = 1'b0;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        y_d     = '0;
        ov_d    = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        y_d       = '0;
        ov_d      = 1'b0;
        w_tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      if (w_transfer) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  decoder_hold_timer u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_tmr_load),
    .load_val_i (c_timer_w'(HOLD_CYCLES - 1)),
    .dec_i      (w_tmr_dec),
    .clr_i      (w_tmr_clr),
    .zero_o     (w_tmr_zero)
  );

  assign Y          = y_q;
  assign out_valid  = ov_q;
  assign accept_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_pulse.sv
//------------------------------------------------------------------------------
// tb_decoder_pulse : vector table, corner sequences and random run vs. model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decoder_pulse;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] Y;
  logic       out_valid;
  logic [7:0] accept_cnt;

  always #5 clk = ~clk;

  decoder_pulse #(.HOLD_CYCLES(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready),
    .Y          (Y),
    .out_valid  (out_valid),
    .accept_cnt (accept_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference: time elapsed since the last accepted code decides everything.
  bit         m_active;
  int         m_since;
  logic [2:0] m_code;
  logic [7:0] m_cnt;

  function automatic logic [7:0] m_y();
    return (m_active && m_since < H) ? (8'd1 << m_code) : 8'd0;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_since  = 0;
    m_code   = 3'd0;
    m_cnt    = 8'd0;
  endtask

  // Entered and left at posedge+1.
  task automatic step(input logic e, input logic v, input logic [2:0] c,
                      output bit xfer, output logic rdy);
    bit m_ready;
    en = e; in_valid = v; in_code = c;
    #1;
    m_ready = e && !m_active;
    rdy     = in_ready;
    chk("in_ready", {7'd0, in_ready}, {7'd0, m_ready});
    xfer = m_ready && v;
    @(posedge clk);
    cyc++;
    if (xfer) begin
      m_active = 1'b1; m_since = 0; m_code = c; m_cnt = m_cnt + 8'd1;
    end else if (m_active) begin
      if (!e) m_active = 1'b0;
      else begin
        m_since++;
        if (m_since == H + 1) m_active = 1'b0;
      end
    end
    #1;
    chk("Y", Y, m_y());
    chk("out_valid", {7'd0, out_valid}, {7'd0, (m_active && m_since < H)});
    chk("accept_cnt", accept_cnt, m_cnt);
    chk("Y_onehot0", {7'd0, $onehot0(Y)}, 8'd1);
  endtask

  task automatic do_reset();
    en = 1'b1; in_valid = 1'b1; in_code = 3'd2;
    rst = 1'b1;
    #3;
    chk("rst_Y", Y, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_accept_cnt", accept_cnt, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0; in_valid = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       e;
    logic       v;
    logic [2:0] c;
    logic       rdy;
    logic [7:0] y;
    logic       ov;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    bit   x;
    logic r;
    int   prev;
    bit   got;

    tbl[0]  = '{1'b1, 1'b1, 3'd5, 1'b1, 8'h20, 1'b1, 8'd1};
    tbl[1]  = '{1'b1, 1'b1, 3'd2, 1'b0, 8'h20, 1'b1, 8'd1};
    tbl[2]  = '{1'b1, 1'b1, 3'd7, 1'b0, 8'h20, 1'b1, 8'd1};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 8'd1};
    tbl[4]  = '{1'b1, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 1'b1, 3'd3, 1'b1, 8'h08, 1'b1, 8'd2};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 8'd2};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'd2};
    tbl[9]  = '{1'b1, 1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 8'd3};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h40, 1'b1, 8'd3};

    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_code = 3'd0;
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].e, tbl[i].v, tbl[i].c, x, r);
      chk("tbl_ready", {7'd0, r}, {7'd0, tbl[i].rdy});
      chk("tbl_Y", Y, tbl[i].y);
      chk("tbl_out_valid", {7'd0, out_valid}, {7'd0, tbl[i].ov});
      chk("tbl_accept_cnt", accept_cnt, tbl[i].cnt);
    end

    // Asynchronous reset in the middle of a 0x40 hold.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_Y", Y, 8'd0);
    chk("async_rst_cnt", accept_cnt, 8'd0);
    chk("async_rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("async_rst_ready", {7'd0, in_ready}, 8'd0);
    #2 rst = 1'b0;
    model_reset();
    en = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 3'd4, x, r);
    chk("post_rst_accept_Y", Y, 8'h10);

    // Back-to-back sweep with in_valid held high.
    do_reset();
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        step(1'b1, 1'b1, 3'(k), x, r);
        if (x) begin
          got = 1'b1;
          chk("sweep_Y", Y, 8'd1 << k);
          if (k > 0) chk("sweep_spacing", 8'(cyc - prev), 8'(H + 2));
          prev = cyc;
        end
      end
      if (!got) chk("sweep_timeout", 8'd0, 8'd1);
    end
    chk("sweep_cnt", accept_cnt, 8'd8);

    // Counter wrap after 256 transfers.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        step(1'b1, 1'b1, 3'($urandom_range(0, 7)), x, r);
        got = x;
      end
      if (!got) chk("wrap_timeout", 8'd0, 8'd1);
    end
    chk("wrap_cnt", accept_cnt, 8'd0);

    // Random traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), x, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decoder_pulse.md
DECODER_PULSE -- requirements
Module: decoder_pulse

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of clock cycles a decoded one-hot output is held (legal 1..255).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port en  input  1  block enable; low blocks acceptance and aborts a hold in progress.
REQ-005 Port in_valid  input  1  code on in_code is valid this cycle.
REQ-006 Port in_code  input  3  binary code 0..7 to decode.
REQ-007 Port in_ready  output  1  block can accept a code this cycle.
REQ-008 Port Y  output  8  registered one-hot output, bit in_code set.
REQ-009 Port out_valid  output  1  Y currently carries a decoded code.
REQ-010 Port accept_cnt  output  8  count of accepted codes, wraps.

Function
REQ-011 Transfer occurs on a rising edge where in_valid and in_ready are both high; no other edge captures in_code.
REQ-012 in_ready is combinational: high only when state is IDLE and en is high.
REQ-013 States: IDLE, HOLD, GAP; encoding fixed in the shared package.
REQ-014 IDLE -> HOLD on transfer; at that edge Y loads 8'b1 << in_code, out_valid goes high, hold timer loads HOLD_CYCLES-1.
REQ-015 HOLD: Y and out_valid stay constant; timer decrements each edge; at the edge with timer = 0, HOLD -> GAP.
REQ-016 Y is therefore non-zero for exactly HOLD_CYCLES clock cycles per transfer; latency from transfer edge to Y valid is zero cycles after that edge (registered output).
REQ-017 GAP lasts exactly one cycle with Y = 0, out_valid = 0, in_ready = 0, then -> IDLE.
REQ-018 Minimum spacing between consecutive transfer edges is HOLD_CYCLES+2 cycles.
REQ-019 en low during HOLD or GAP: next edge forces IDLE, Y = 0, out_valid = 0; aborted transfers remain counted.
REQ-020 in_valid high while in_ready low: code ignored, no state change; upstream must hold it (valid/ready semantics).
REQ-021 accept_cnt increments by 1 on every transfer edge, 8-bit modulo (255 -> 0).
REQ-022 Y is always either all-zero or exactly one-hot; never multiple bits.
REQ-023 Illegal state encoding recovers to IDLE with Y = 0 on the next edge.

Reset
REQ-024 rst high immediately (without clock) sets state IDLE, Y = 8'b0, out_valid = 0, timer = 0, accept_cnt = 0.
REQ-025 rst asserted mid-HOLD discards the hold; after rst release the first edge may accept a new code if en and in_valid are high.
REQ-026 in_ready is low while rst is high.

Structure
REQ-027 Shared package decoder_pkg holds state encodings (IDLE, HOLD, GAP), code width 3, output width 8, timer width 8.
REQ-028 Hold timer is a separate sub-module decoder_hold_timer (load, decrement, zero flag, async reset).
REQ-029 Top contains the FSM, one-hot output register and accept counter; no other sub-modules.

Verification (HOLD_CYCLES = 4)
REQ-030 Reset then en=1, in_valid=1, in_code=5 one cycle -> Y=8'b00100000 for 4 cycles, one GAP cycle of Y=0, in_ready high again on the 6th cycle after transfer, accept_cnt=1.
REQ-031 Sweep in_code 0..7 back-to-back with in_valid held high -> Y walks 00000001..10000000, transfers spaced exactly 6 cycles, accept_cnt=8.
REQ-032 in_code=3 accepted, en dropped on 2nd hold cycle -> Y=0 and out_valid=0 next edge, state IDLE, accept_cnt still 1.
REQ-033 rst pulsed asynchronously (between clock edges) mid-HOLD with Y=8'b01000000 -> Y=0, accept_cnt=0 before next edge.
REQ-034 256 transfers -> accept_cnt wraps to 0; checker asserts Y one-hot-or-zero every cycle throughout all scenarios.
REQ-035 in_valid high with in_code changing during HOLD -> Y unchanged, no extra count.
